wb_pipeline_master: RTL and testbench
=====================================

Name: wb_pipeline_master

Overview:
- Synthesizable pipelined, non-burst Wishbone master for the NIC base.
- Converts one NIC bus command (write of N data beats, or read of N beats) into a single Wishbone cycle.
- Write data is popped from the NIC flit buffer; read data is pushed back to the NIC.
- Sits directly upstream of the Wishbone slave/arbiter. CYC_O doubles as the arbitration request; the arbiter answers on gnt_wb_i.

Parameters:
- MAX_BEATS, `MAX_BURST_LENGHT: maximum beats per command.
- LEN_W, 4: width of cmd_len_i.
- ACK_TIMEOUT, 64: cycles without ACK/ERR/RTY before abort.
- MAX_RETRY, 3: RTY_I-triggered reissues before failure.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  command accepted (IDLE only)
- cmd_we_i  in  1  1 = write, 0 = read
- cmd_adr_i  in  `BUS_ADDRESS_WIDTH  NIC address (src/dest/cmd fields)
- cmd_len_i  in  LEN_W  beats, 1..MAX_BEATS
- wr_data_i  in  `BUS_DATA_WIDTH  first-word-fall-through buffer head
- wr_pop_o  out  1  buffer pop, one per accepted write beat
- rd_data_o  out  `BUS_DATA_WIDTH  read beat
- rd_valid_o  out  1  rd_data_o valid, one cycle per ACK
- done_o  out  1  one-cycle pulse, command completed OK
- err_o  out  1  one-cycle pulse, command failed
- gnt_wb_i  in  1  bus grant
- CYC_O, STB_O, WE_O  out  1 each  Wishbone controls
- ADR_O  out  `BUS_ADDRESS_WIDTH  address
- DAT_O  out  `BUS_DATA_WIDTH  write data
- SEL_O  out  `BUS_DATA_WIDTH/`GRANULARITY  byte selects
- CTI_O  out  3  cycle type
- DAT_I  in  `BUS_DATA_WIDTH  read data
- ACK_I, RTY_I, ERR_I, STALL_I  in  1 each  slave responses

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0 except cmd_ready_o = 1; counters and retry count cleared.
- **IDLE**
  - cmd_ready_o = 1.
  - On cmd_valid_i: latch we/adr/len, clear counters, go to ARB.
  - cmd_len_i = 0 is treated as 1.
  - cmd_len_i > MAX_BEATS: err_o pulse, stay IDLE.
- **ARB**
  - CYC_O = 1, WE_O and ADR_O valid, STB_O = 0.
  - WE_O is stable from the first CYC_O cycle until CYC_O drops.
  - gnt_wb_i sampled high goes to XFER on the next edge.
  - The timeout counter also runs here.
- **XFER**
  - STB_O = 1 while issued < len.
  - A beat is accepted on an edge with STB_O & !STALL_I: issued++.
  - On a write, wr_pop_o is asserted in the same cycle; DAT_O = wr_data_i.
  - ADR_O is constant for every beat. CTI_O = 3'b000. SEL_O = all ones.
  - Issuing and acknowledging overlap (pipelined).
  - When issued reaches len, STB_O = 0 from the next cycle.
- **ACK handling** (any state with CYC_O = 1)
  - Each ACK_I: acked++.
  - On a read: rd_data_o = DAT_I registered, rd_valid_o = 1 for that one cycle.
  - When acked reaches len: go to DONE.
  - ACK_I, ERR_I or RTY_I while acked == issued are ignored.
- **DONE**
  - CYC_O = 0 for at least 1 cycle (the slave resets on CYC low).
  - done_o pulses, retry count cleared, return to IDLE.
- **RTY_I**
  - Drop CYC_O/STB_O, go to BACKOFF for 1 cycle.
  - If retries < MAX_RETRY: retries++, reissue from ARB with counters cleared.
  - Writes need the data replayed, so RTY on a write is failed immediately rather than replayed.
  - Otherwise go to FAIL.
- **ERR_I or timeout** (ACK_TIMEOUT consecutive cycles in ARB/XFER without gnt progress or response): go to FAIL.
- **FAIL**: CYC_O = 0 for 1 cycle, err_o pulses, go to IDLE.
- **Simultaneous events**
  - ACK_I and ERR_I in the same cycle: ERR wins, the beat is not counted.
  - The final ACK coinciding with STALL_I is still counted.
- **Counters**: issued and acked are LEN_W+1 bits wide; acked never exceeds issued.
- **Reset mid-operation**: all outputs drop asynchronously. No done_o or err_o is produced.

Test Plan:
- Write, len = 3, adr = 0x0000_0123, slave gnt after 1 cycle, no stall → 3 STB beats carrying buffer words W0..W2, 3 wr_pop_o pulses, CYC low for ≥1 cycle, one done_o, WE_O = 1 throughout.
- Read, len = 4, pipeline ACK latency 2 → STB high for 4 consecutive cycles after gnt, 4 rd_valid_o pulses with DAT_I in order, done_o 1 cycle after the 4th ACK.
- Write, len = 4, STALL_I high on alternate cycles → exactly 4 accepted beats, no duplicated or skipped pop; DAT_O held during stall.
- Read, RTY_I on beat 2 → CYC drops, a second full cycle is issued; on success, exactly one done_o. With MAX_RETRY = 0, err_o instead.
- Gnt never arrives → err_o exactly ACK_TIMEOUT = 64 cycles after CYC rise; CYC_O then 0, return to IDLE.
- rst asserted while 2 of 4 read beats are acked → CYC_O/STB_O go to 0 immediately, no done_o; a new command after release completes normally.

Source files
------------

// File: rtl/wb_pipeline_master.sv
// Pipelined single-cycle Wishbone master: one NIC command (N write or read beats) becomes one CYC.
// STB issues back-to-back while STALL_I is low; read data returns one cycle after each ACK.
`ifndef BUS_ADDRESS_WIDTH
`define BUS_ADDRESS_WIDTH 32
`endif
`ifndef BUS_DATA_WIDTH
`define BUS_DATA_WIDTH 32
`endif
`ifndef GRANULARITY
`define GRANULARITY 8
`endif
`ifndef MAX_BURST_LENGHT
`define MAX_BURST_LENGHT 8
`endif

module wb_pipeline_master #(
  parameter int MAX_BEATS   = `MAX_BURST_LENGHT,
  parameter int LEN_W       = 4,
  parameter int ACK_TIMEOUT = 64,
  parameter int MAX_RETRY   = 3
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       cmd_valid_i,
  output logic                                       cmd_ready_o,
  input  logic                                       cmd_we_i,
  input  logic [`BUS_ADDRESS_WIDTH-1:0]              cmd_adr_i,
  input  logic [LEN_W-1:0]                           cmd_len_i,
  input  logic [`BUS_DATA_WIDTH-1:0]                 wr_data_i,
  output logic                                       wr_pop_o,
  output logic [`BUS_DATA_WIDTH-1:0]                 rd_data_o,
  output logic                                       rd_valid_o,
  output logic                                       done_o,
  output logic                                       err_o,
  input  logic                                       gnt_wb_i,
  output logic                                       CYC_O,
  output logic                                       STB_O,
  output logic                                       WE_O,
  output logic [`BUS_ADDRESS_WIDTH-1:0]              ADR_O,
  output logic [`BUS_DATA_WIDTH-1:0]                 DAT_O,
  output logic [`BUS_DATA_WIDTH/`GRANULARITY-1:0]    SEL_O,
  output logic [2:0]                                 CTI_O,
  input  logic [`BUS_DATA_WIDTH-1:0]                 DAT_I,
  input  logic                                       ACK_I,
  input  logic                                       RTY_I,
  input  logic                                       ERR_I,
  input  logic                                       STALL_I
);
  localparam int AW = `BUS_ADDRESS_WIDTH;
  localparam int DW = `BUS_DATA_WIDTH;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);

  typedef enum logic [2:0] {IDLE, ARB, XFER, DONE, BACKOFF, FAIL} state_t;

  state_t          state_q, state_d;
  logic            we_q;
  logic [AW-1:0]   adr_q;
  logic [LEN_W:0]  len_q, issued_q, acked_q;
  logic [TW-1:0]   tmo_q;
  logic [RW-1:0]   retry_q;
  logic            bad_len_q, rd_valid_q;
  logic [DW-1:0]   rd_data_q;

  logic            cyc, stb, beat, resp_ok, ack_ev, err_ev, rty_ev, progress, tmo_hit, len_bad;
  logic [LEN_W:0]  len_eff;

  assign len_eff = (cmd_len_i == '0) ? (LEN_W+1)'(1) : {1'b0, cmd_len_i};
  assign len_bad = {1'b0, cmd_len_i} > (LEN_W+1)'(MAX_BEATS);

  assign cyc  = (state_q == ARB) || (state_q == XFER);
  assign stb  = (state_q == XFER) && (issued_q < len_q);
  assign beat = stb && !STALL_I;

  // Responses only count while a beat is outstanding; ERR beats ACK, RTY beats ACK.
  assign resp_ok  = cyc && (acked_q != issued_q);
  assign err_ev   = resp_ok && ERR_I;
  assign rty_ev   = resp_ok && RTY_I && !ERR_I;
  assign ack_ev   = resp_ok && ACK_I && !ERR_I && !RTY_I;
  assign progress = ((state_q == ARB) && gnt_wb_i) || beat || ack_ev;
  assign tmo_hit  = cyc && !progress && (tmo_q == TW'(ACK_TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (cmd_valid_i && !len_bad) state_d = ARB;
      ARB, XFER: begin
        if (err_ev || tmo_hit)                                  state_d = FAIL;
        else if (rty_ev)                                        state_d = BACKOFF;
        else if (ack_ev && (acked_q + (LEN_W+1)'(1) == len_q))  state_d = DONE;
        else if ((state_q == ARB) && gnt_wb_i)                  state_d = XFER;
      end
      // A write cannot be replayed because its data has already been popped.
      BACKOFF:   state_d = (!we_q && (retry_q < RW'(MAX_RETRY))) ? ARB : FAIL;
      DONE:      state_d = IDLE;
      FAIL:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      adr_q      <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      acked_q    <= '0;
      tmo_q      <= '0;
      retry_q    <= '0;
      bad_len_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      bad_len_q  <= (state_q == IDLE) && cmd_valid_i && len_bad;
      rd_valid_q <= ack_ev && !we_q;
      if (ack_ev && !we_q) rd_data_q <= DAT_I;
      case (state_q)
        IDLE: if (cmd_valid_i && !len_bad) begin
          we_q     <= cmd_we_i;
          adr_q    <= cmd_adr_i;
          len_q    <= len_eff;
          issued_q <= '0;
          acked_q  <= '0;
          tmo_q    <= '0;
          retry_q  <= '0;
        end
        ARB, XFER: begin
          if (beat)   issued_q <= issued_q + (LEN_W+1)'(1);
          if (ack_ev) acked_q  <= acked_q + (LEN_W+1)'(1);
          tmo_q <= progress ? '0 : tmo_q + TW'(1);
        end
        BACKOFF: begin
          issued_q <= '0;
          acked_q  <= '0;
          tmo_q    <= '0;
          if (state_d == ARB) retry_q <= retry_q + RW'(1);
        end
        DONE:    retry_q <= '0;
        FAIL:    retry_q <= '0;
        default: ;
      endcase
    end
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign CYC_O       = cyc;
  assign STB_O       = stb;
  assign WE_O        = cyc && we_q;
  assign ADR_O       = cyc ? adr_q : '0;
  assign DAT_O       = (stb && we_q) ? wr_data_i : '0;
  assign SEL_O       = cyc ? '1 : '0;
  assign CTI_O       = 3'b000;
  assign wr_pop_o    = beat && we_q;
  assign rd_valid_o  = rd_valid_q;
  assign rd_data_o   = rd_data_q;
  assign done_o      = (state_q == DONE);
  assign err_o       = (state_q == FAIL) || bad_len_q;

endmodule

// File: tb/tb_wb_pipeline_master.sv
// Directed bench for wb_pipeline_master: scripted pipelined slave, write buffer and read scoreboard.
// A second instance with MAX_RETRY = 0 shares all inputs to cover the no-retry failure path.
module tb_wb_pipeline_master;
  localparam logic [31:0] WBASE = 32'hA000_0000;
  localparam logic [31:0] RBASE = 32'hD000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        cmd_valid_i, cmd_we_i, gnt_wb_i, ACK_I, RTY_I, ERR_I, STALL_I;
  logic [31:0] cmd_adr_i, wr_data_i, DAT_I;
  logic [3:0]  cmd_len_i;

  logic        cmd_ready_o, wr_pop_o, rd_valid_o, done_o, err_o, CYC_O, STB_O, WE_O;
  logic [31:0] rd_data_o, ADR_O, DAT_O;
  logic [3:0]  SEL_O;
  logic [2:0]  CTI_O;

  logic        d0_cmd_ready_o, d0_wr_pop_o, d0_rd_valid_o, d0_done_o, d0_err_o, d0_CYC_O, d0_STB_O, d0_WE_O;
  logic [31:0] d0_rd_data_o, d0_ADR_O, d0_DAT_O;
  logic [3:0]  d0_SEL_O;
  logic [2:0]  d0_CTI_O;

  wb_pipeline_master #(.MAX_RETRY(3)) dut (
    .clk(clk), .rst(rst), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_we_i(cmd_we_i), .cmd_adr_i(cmd_adr_i), .cmd_len_i(cmd_len_i),
    .wr_data_i(wr_data_i), .wr_pop_o(wr_pop_o), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
    .done_o(done_o), .err_o(err_o), .gnt_wb_i(gnt_wb_i), .CYC_O(CYC_O), .STB_O(STB_O),
    .WE_O(WE_O), .ADR_O(ADR_O), .DAT_O(DAT_O), .SEL_O(SEL_O), .CTI_O(CTI_O), .DAT_I(DAT_I),
    .ACK_I(ACK_I), .RTY_I(RTY_I), .ERR_I(ERR_I), .STALL_I(STALL_I));

  wb_pipeline_master #(.MAX_RETRY(0)) dut0 (
    .clk(clk), .rst(rst), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(d0_cmd_ready_o),
    .cmd_we_i(cmd_we_i), .cmd_adr_i(cmd_adr_i), .cmd_len_i(cmd_len_i),
    .wr_data_i(wr_data_i), .wr_pop_o(d0_wr_pop_o), .rd_data_o(d0_rd_data_o), .rd_valid_o(d0_rd_valid_o),
    .done_o(d0_done_o), .err_o(d0_err_o), .gnt_wb_i(gnt_wb_i), .CYC_O(d0_CYC_O), .STB_O(d0_STB_O),
    .WE_O(d0_WE_O), .ADR_O(d0_ADR_O), .DAT_O(d0_DAT_O), .SEL_O(d0_SEL_O), .CTI_O(d0_CTI_O), .DAT_I(DAT_I),
    .ACK_I(ACK_I), .RTY_I(RTY_I), .ERR_I(ERR_I), .STALL_I(STALL_I));

  int vectors = 0;
  int miscompares = 0;

  // slave configuration
  int   gnt_delay, ack_lat, rty_beat, err_beat;
  logic gnt_never, stall_alt, rty_armed;
  // per-command observations
  int   t, n_pop, n_beats, n_rdv, rd_bad, n_done, n_err, d0_done, d0_err;
  int   we_bad, dat_bad, adr_bad, cyc_rises, stb_cnt, t_rise, t_err, t_done, t_ack;
  int   t_stb_first, t_stb_last, cyc_cnt, ack_idx, pop_idx;
  logic cyc_at_end, cyc_prev, cur_we;
  logic [31:0] cur_adr;
  int          pend[$];
  logic [31:0] rd_exp[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cfg(input int gd, input int lat, input logic stall, input int rb, input int eb, input logic never);
    gnt_delay = gd; ack_lat = lat; stall_alt = stall; rty_beat = rb; err_beat = eb; gnt_never = never;
  endtask

  task automatic clear_stats();
    n_pop = 0; n_beats = 0; n_rdv = 0; rd_bad = 0; n_done = 0; n_err = 0; d0_done = 0; d0_err = 0;
    we_bad = 0; dat_bad = 0; adr_bad = 0; cyc_rises = 0; stb_cnt = 0; t_rise = 0; t_err = 0;
    t_done = 0; t_ack = 0; t_stb_first = 0; t_stb_last = 0; cyc_cnt = 0; ack_idx = 0; pop_idx = 0;
    cyc_at_end = 1'b1; rty_armed = (rty_beat > 0);
    pend.delete(); rd_exp.delete();
  endtask

  // One clock: sample registered outputs at negedge, drive the slave, then sample combinational outputs.
  task automatic step();
    @(negedge clk);
    t++;
    if (rd_valid_o) begin
      n_rdv++;
      if (rd_exp.size() == 0) rd_bad++;
      else if (rd_data_o !== rd_exp.pop_front()) rd_bad++;
    end
    if (done_o) begin n_done++; t_done = t; cyc_at_end = CYC_O; end
    if (err_o) begin n_err++; t_err = t; cyc_at_end = CYC_O; end
    if (d0_done_o) d0_done++;
    if (d0_err_o) d0_err++;
    if (CYC_O && !cyc_prev) begin cyc_rises++; t_rise = t; cyc_cnt = 0; ack_idx = 0; end
    if (!CYC_O) begin pend.delete(); cyc_cnt = 0; end
    if (CYC_O && (WE_O !== cur_we)) we_bad++;
    cyc_prev = CYC_O;

    wr_data_i = WBASE + pop_idx;
    gnt_wb_i  = CYC_O && !gnt_never && (cyc_cnt >= gnt_delay);
    STALL_I   = stall_alt && t[0];
    ACK_I = 1'b0; RTY_I = 1'b0; ERR_I = 1'b0;
    if (CYC_O && pend.size() > 0 && pend[0] == t) begin
      void'(pend.pop_front());
      ack_idx++;
      t_ack = t;
      if (rty_armed && ack_idx == rty_beat) begin
        RTY_I = 1'b1; rty_armed = 1'b0;
      end else begin
        ACK_I = 1'b1;
        if (ack_idx == err_beat) ERR_I = 1'b1;
        else if (!cur_we) begin
          DAT_I = RBASE + ack_idx;
          rd_exp.push_back(RBASE + ack_idx);
        end
      end
    end
    if (CYC_O) cyc_cnt++;

    #1;
    if (STB_O) begin
      if (stb_cnt == 0) t_stb_first = t;
      t_stb_last = t;
      stb_cnt++;
      if (ADR_O !== cur_adr) adr_bad++;
      if (cur_we && (DAT_O !== WBASE + n_beats)) dat_bad++;
      if (!STALL_I) begin n_beats++; pend.push_back(t + ack_lat); end
    end
    if (wr_pop_o) begin n_pop++; pop_idx++; end
  endtask

  task automatic run_cmd(input logic we, input logic [31:0] adr, input logic [3:0] len, input int budget);
    clear_stats();
    cur_we = we; cur_adr = adr;
    check("cmd_ready", cmd_ready_o, 1);
    cmd_we_i = we; cmd_adr_i = adr; cmd_len_i = len; cmd_valid_i = 1'b1;
    step();
    cmd_valid_i = 1'b0;
    for (int k = 0; k < budget && (n_done + n_err) == 0; k++) step();
    check("finish", (n_done + n_err) != 0, 1);
    repeat (3) step();
  endtask

  initial begin
    cmd_valid_i = 0; cmd_we_i = 0; cmd_adr_i = 0; cmd_len_i = 0; wr_data_i = 0; DAT_I = 0;
    gnt_wb_i = 0; ACK_I = 0; RTY_I = 0; ERR_I = 0; STALL_I = 0;
    t = 0; cyc_prev = 0; cur_we = 0; cur_adr = 0;
    cfg(1, 1, 0, 0, 0, 0);
    clear_stats();

    repeat (2) @(negedge clk);
    check("rst_ready", cmd_ready_o, 1);
    check("rst_cyc", CYC_O, 0);
    check("rst_stb", STB_O, 0);
    check("rst_done_err", {done_o, err_o, rd_valid_o, wr_pop_o}, 0);
    rst = 1'b1;

    // write len 3, grant after one cycle
    cfg(1, 1, 0, 0, 0, 0);
    run_cmd(1'b1, 32'h0000_0123, 4'd3, 60);
    check("w3_beats", n_beats, 3);
    check("w3_pops", n_pop, 3);
    check("w3_data", dat_bad, 0);
    check("w3_we", we_bad, 0);
    check("w3_adr", adr_bad, 0);
    check("w3_done", n_done, 1);
    check("w3_err", n_err, 0);
    check("w3_cyc_low", cyc_at_end, 0);

    // read len 4, ACK latency 2
    cfg(1, 2, 0, 0, 0, 0);
    run_cmd(1'b0, 32'h0000_0400, 4'd4, 60);
    check("r4_stb", stb_cnt, 4);
    check("r4_stb_run", t_stb_last - t_stb_first, 3);
    check("r4_rdv", n_rdv, 4);
    check("r4_order", rd_bad, 0);
    check("r4_done", n_done, 1);
    check("r4_done_lat", t_done - t_ack, 1);

    // write len 4, stall on alternate cycles
    cfg(1, 1, 1, 0, 0, 0);
    run_cmd(1'b1, 32'h0000_0800, 4'd4, 60);
    check("ws_beats", n_beats, 4);
    check("ws_pops", n_pop, 4);
    check("ws_data", dat_bad, 0);
    check("ws_stalled", (stb_cnt >= 7) && (stb_cnt <= 8), 1);
    check("ws_done", n_done, 1);

    // read len 4, RTY on beat 2: retried here, fails with MAX_RETRY = 0
    cfg(1, 1, 0, 2, 0, 0);
    run_cmd(1'b0, 32'h0000_0C00, 4'd4, 80);
    check("rr_cycles", cyc_rises, 2);
    check("rr_done", n_done, 1);
    check("rr_err", n_err, 0);
    check("rr_rdv", n_rdv, 5);
    check("rr_order", rd_bad, 0);
    check("rr0_err", d0_err, 1);
    check("rr0_done", d0_done, 0);

    // grant never arrives
    cfg(1, 1, 0, 0, 0, 1);
    run_cmd(1'b0, 32'h0000_1000, 4'd1, 200);
    check("to_err", n_err, 1);
    check("to_delay", t_err - t_rise, 64);
    check("to_cyc_low", cyc_at_end, 0);
    check("to_done", n_done, 0);
    check("to_idle", cmd_ready_o, 1);

    // length above MAX_BEATS is refused without a bus cycle
    cfg(1, 1, 0, 0, 0, 0);
    run_cmd(1'b0, 32'h0000_1400, 4'd9, 20);
    check("bl_err", n_err, 1);
    check("bl_cyc", cyc_rises, 0);

    // length 0 behaves as a single beat
    run_cmd(1'b0, 32'h0000_1800, 4'd0, 40);
    check("l0_stb", stb_cnt, 1);
    check("l0_rdv", n_rdv, 1);
    check("l0_done", n_done, 1);

    // ACK and ERR together on beat 2: error wins, beat not delivered
    cfg(1, 1, 0, 0, 2, 0);
    run_cmd(1'b0, 32'h0000_1C00, 4'd3, 40);
    check("ae_err", n_err, 1);
    check("ae_done", n_done, 0);
    check("ae_rdv", n_rdv, 1);

    // RTY on a write is not replayed
    cfg(1, 1, 0, 1, 0, 0);
    run_cmd(1'b1, 32'h0000_2000, 4'd2, 40);
    check("wr_err", n_err, 1);
    check("wr_done", n_done, 0);
    check("wr_cycles", cyc_rises, 1);

    // reset while 2 of 4 read beats are acked
    cfg(1, 2, 0, 0, 0, 0);
    clear_stats();
    cur_we = 1'b0; cur_adr = 32'h0000_2400;
    cmd_we_i = 1'b0; cmd_adr_i = cur_adr; cmd_len_i = 4'd4; cmd_valid_i = 1'b1;
    step();
    cmd_valid_i = 1'b0;
    for (int k = 0; k < 50 && n_rdv < 2; k++) step();
    check("mr_reach", n_rdv, 2);
    rst = 1'b0;
    #1;
    check("mr_cyc", CYC_O, 0);
    check("mr_stb", STB_O, 0);
    repeat (3) step();
    check("mr_no_done", n_done, 0);
    check("mr_no_err", n_err, 0);
    rst = 1'b1;
    run_cmd(1'b0, 32'h0000_2800, 4'd2, 40);
    check("mr_rdv", n_rdv, 2);
    check("mr_order", rd_bad, 0);
    check("mr_done", n_done, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
